// File: rtl/wall_control_if.sv
// rtl/wall_control_if.sv - pixel stream between the wall sequencer and the VGA plotter
// Signals:
//   plot        pixel valid
//   x, y        pixel coordinate (x 0..159, y 0..119)
//   colour      3-bit pixel colour
//   plot_ready  plotter accepts the current pixel this cycle
interface wall_control_if;
    logic       plot;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot_ready;

    modport master (
        output plot,
        output x,
        output y,
        output colour,
        input  plot_ready
    );

    modport slave (
        input  plot,
        input  x,
        input  y,
        input  colour,
        output plot_ready
    );
endinterface

// File: rtl/wall_control.sv
// rtl/wall_control.sv - scrolling-wall frame sequencer streaming pixels to the VGA plotter
// Ports:
//   clk, resetn        clock, asynchronous active-low reset
//   go                 level: run the game while high
//   halt               level: collision freeze, honoured only while waiting for a frame
//   pix (master)       plot/x/y/colour pixel stream with plot_ready back-pressure
//   wall_x             current wall left edge
//   hole_top           first row of the hole
//   busy               high during erase, move and draw
//   frame_done         one-cycle pulse after the last drawn coordinate
module wall_control #(
    parameter int         FRAME_DIV   = 833333,
    parameter int         WALL_SPEED  = 4,
    parameter int         WALL_W      = 4,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter int         HOLE_H      = 40,
    parameter logic [2:0] WALL_COLOUR = 3'b010
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  go,
    input  logic                  halt,
    wall_control_if.master        pix,
    output logic [7:0]            wall_x,
    output logic [6:0]            hole_top,
    output logic                  busy,
    output logic                  frame_done
);

    localparam int              CNT_W      = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(FRAME_DIV - 1);
    localparam logic [7:0]      X_RELOAD   = 8'(SCREEN_W);
    localparam logic [7:0]      X_SPEED    = 8'(WALL_SPEED);
    localparam logic [7:0]      X_SPAN     = 8'(WALL_W - 1);
    localparam logic [6:0]      Y_LAST     = 7'(SCREEN_H - 1);
    localparam logic [6:0]      HOLE_RESET = 7'd40;
    localparam logic [6:0]      HOLE_BASE  = 7'd8;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_FRAME,
        ERASE,
        MOVE,
        DRAW
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pending_q, pending_d;
    logic [7:0]       lfsr_q, lfsr_d;
    logic [7:0]       wall_x_q, wall_x_d;
    logic [6:0]       hole_q, hole_d;
    logic             plot_q, plot_d;
    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       colour_q, colour_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             cnt_wrap;
    logic [7:0]       x_end;
    logic             advance;
    logic             last_coord;
    logic [7:0]       nx;
    logic [6:0]       ny;

    // Solid wall everywhere except the HOLE_H rows starting at top.
    function automatic logic [2:0] row_colour(input logic [6:0] row, input logic [6:0] top);
        logic [7:0] r;
        logic [7:0] t;
        r = {1'b0, row};
        t = {1'b0, top};
        if ((r >= t) && (r < t + 8'(HOLE_H))) begin
            return 3'b000;
        end
        return WALL_COLOUR;
    endfunction

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pending_d  = pending_q;
        wall_x_d   = wall_x_q;
        hole_d     = hole_q;
        plot_d     = plot_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        done_d     = 1'b0;
        // Fibonacci taps 8,6,5,4; the all-zero state is unreachable from 8'hA5.
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

        cnt_wrap   = (state_q != IDLE) && (cnt_q == CNT_LAST);
        x_end      = wall_x_q + X_SPAN;
        // A clipped coordinate (plot low) retires in one cycle regardless of ready.
        advance    = !plot_q || pix.plot_ready;
        last_coord = (y_q == Y_LAST) && (x_q == x_end);
        if (x_q == x_end) begin
            nx = wall_x_q;
            ny = y_q + 7'd1;
        end else begin
            nx = x_q + 8'd1;
            ny = y_q;
        end

        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (cnt_wrap) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        // One-deep: a wrap while already pending changes nothing.
        if (cnt_wrap) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                plot_d = 1'b0;
                if (go) begin
                    // Initial wall is drawn in place; there is nothing to erase yet.
                    state_d  = DRAW;
                    x_d      = wall_x_q;
                    y_d      = 7'd0;
                    plot_d   = wall_x_q < X_RELOAD;
                    colour_d = row_colour(7'd0, hole_q);
                end
            end
            WAIT_FRAME: begin
                plot_d = 1'b0;
                if (!go) begin
                    state_d = IDLE;
                end else if (!halt && pending_q) begin
                    // Consuming the tick wins over a wrap landing in the same cycle.
                    pending_d = 1'b0;
                    state_d   = ERASE;
                    x_d       = wall_x_q;
                    y_d       = 7'd0;
                    plot_d    = wall_x_q < X_RELOAD;
                    colour_d  = 3'b000;
                end
            end
            ERASE, DRAW: begin
                if (advance) begin
                    if (last_coord) begin
                        plot_d = 1'b0;
                        if (state_q == ERASE) begin
                            state_d = MOVE;
                        end else begin
                            state_d = WAIT_FRAME;
                            done_d  = 1'b1;
                        end
                    end else begin
                        x_d      = nx;
                        y_d      = ny;
                        plot_d   = nx < X_RELOAD;
                        colour_d = (state_q == DRAW) ? row_colour(ny, hole_q) : 3'b000;
                    end
                end
            end
            MOVE: begin
                if (wall_x_q < X_SPEED) begin
                    wall_x_d = X_RELOAD;
                    hole_d   = HOLE_BASE + {1'b0, lfsr_q[5:0]};
                end else begin
                    wall_x_d = wall_x_q - X_SPEED;
                end
                state_d  = DRAW;
                x_d      = wall_x_d;
                y_d      = 7'd0;
                plot_d   = wall_x_d < X_RELOAD;
                colour_d = row_colour(7'd0, hole_d);
            end
            default: begin
                state_d = IDLE;
                plot_d  = 1'b0;
            end
        endcase

        busy_d = (state_d == ERASE) || (state_d == MOVE) || (state_d == DRAW);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            pending_q <= 1'b0;
            lfsr_q    <= 8'hA5;
            wall_x_q  <= X_RELOAD;
            hole_q    <= HOLE_RESET;
            plot_q    <= 1'b0;
            x_q       <= 8'd0;
            y_q       <= 7'd0;
            colour_q  <= 3'b000;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            lfsr_q    <= lfsr_d;
            wall_x_q  <= wall_x_d;
            hole_q    <= hole_d;
            plot_q    <= plot_d;
            x_q       <= x_d;
            y_q       <= y_d;
            colour_q  <= colour_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign pix.plot   = plot_q;
    assign pix.x      = x_q;
    assign pix.y      = y_q;
    assign pix.colour = colour_q;
    assign wall_x     = wall_x_q;
    assign hole_top   = hole_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_wall_control.sv
// tb/tb_wall_control.sv - scoreboard bench for the wall sequencer
module tb_wall_control;
    localparam int FDIV = 100;

    logic       clk = 1'b0;
    logic       resetn;
    logic       go;
    logic       halt;
    logic [7:0] wall_x;
    logic [6:0] hole_top;
    logic       busy;
    logic       frame_done;

    wall_control_if pix();

    wall_control #(.FRAME_DIV(FDIV)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .halt       (halt),
        .pix        (pix),
        .wall_x     (wall_x),
        .hole_top   (hole_top),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    logic [7:0]  m_lfsr;
    logic [17:0] sb[$];
    int          exp_wall_x;
    int          exp_hole;
    bit          first_busy;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) m_lfsr <= 8'hA5;
        else         m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_pixels(input int wx, input bit draw);
        logic [2:0] c;
        logic [7:0] xb;
        logic [6:0] yb;
        for (int yy = 0; yy < 120; yy++) begin
            for (int xx = wx; xx < wx + 4; xx++) begin
                if (xx < 160) begin
                    c  = (draw && !(yy >= exp_hole && yy < exp_hole + 40)) ? 3'b010 : 3'b000;
                    xb = 8'(xx);
                    yb = 7'(yy);
                    sb.push_back({xb, yb, c});
                end
            end
        end
    endtask

    // Runs one frame (optionally erase+move, always draw), checking every accepted
    // pixel against the scoreboard. rst_at > 0 pulls reset at that accepted pixel.
    task automatic run_frame(input bit with_erase, input bit rnd, input int exp_busy, input int rst_at);
        int          n_busy, n_acc, n_exp, cyc;
        bit          done, aborted, wrapped, prev_stall;
        logic [18:0] prev_pix;
        logic [7:0]  prev_wx, lfsr_prev;
        int          old_wx;
        old_wx = exp_wall_x;
        if (with_erase) begin
            push_pixels(old_wx, 1'b0);
            exp_wall_x = (old_wx < 4) ? 160 : old_wx - 4;
        end
        push_pixels(exp_wall_x, 1'b1);
        n_exp = sb.size();
        n_busy = 0; n_acc = 0; cyc = 0;
        done = 0; aborted = 0; wrapped = 0; prev_stall = 0;
        prev_wx = wall_x; lfsr_prev = m_lfsr; prev_pix = '0;
        while (!done && cyc < 6000) begin
            @(negedge clk);
            if (cyc == 0) first_busy = busy;
            cyc++;
            if (rnd) pix.plot_ready = 1'($urandom_range(0, 1));
            if (prev_stall) chk("stall_stable", {pix.plot, pix.x, pix.y, pix.colour}, prev_pix);
            if (busy) n_busy++;
            if (wall_x != prev_wx && wall_x == 8'd160) begin
                wrapped  = 1;
                exp_hole = 8 + int'(lfsr_prev[5:0]);
            end
            if (pix.plot && pix.plot_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) chk("pixel", {pix.x, pix.y, pix.colour}, sb.pop_front());
                n_acc++;
                if (n_acc == rst_at) begin
                    resetn = 1'b0;
                    #1;
                    chk("rst_plot", pix.plot, 0);
                    chk("rst_busy", busy, 0);
                    chk("rst_wall_x", wall_x, 160);
                    chk("rst_hole_top", hole_top, 40);
                    chk("rst_frame_done", frame_done, 0);
                    aborted = 1;
                    done = 1;
                end
            end
            prev_stall = pix.plot && !pix.plot_ready;
            prev_pix   = {pix.plot, pix.x, pix.y, pix.colour};
            if (frame_done) done = 1;
            prev_wx   = wall_x;
            lfsr_prev = m_lfsr;
        end
        pix.plot_ready = 1'b1;
        if (aborted) begin
            sb.delete();
            exp_wall_x = 160;
            exp_hole   = 40;
        end else begin
            chk("frame_done_seen", 32'(done), 1);
            if (exp_busy >= 0) chk("busy_cycles", n_busy, exp_busy);
            chk("accepted", n_acc, n_exp);
            chk("sb_empty", sb.size(), 0);
            chk("wall_x", wall_x, exp_wall_x);
            chk("hole_top", hole_top, exp_hole);
            if (wrapped) chk("hole_range", 32'(hole_top >= 7'd8 && hole_top <= 7'd71), 1);
        end
    endtask

    initial begin
        int n;
        resetn = 1'b0; go = 1'b0; halt = 1'b0; pix.plot_ready = 1'b1;
        exp_wall_x = 160; exp_hole = 40;
        repeat (3) @(negedge clk);
        chk("reset_plot", pix.plot, 0);
        chk("reset_x", pix.x, 0);
        chk("reset_y", pix.y, 0);
        chk("reset_colour", pix.colour, 0);
        chk("reset_wall_x", wall_x, 160);
        chk("reset_hole_top", hole_top, 40);
        chk("reset_busy", busy, 0);
        chk("reset_frame_done", frame_done, 0);

        resetn = 1'b1; go = 1'b1;
        run_frame(1'b0, 1'b0, 480, -1);
        while (exp_wall_x != 0) run_frame(1'b1, 1'b0, 961, -1);
        run_frame(1'b1, 1'b0, 961, -1);
        chk("wrapped_wall_x", wall_x, 160);

        run_frame(1'b1, 1'b1, -1, -1);

        halt = 1'b1;
        n = 0;
        repeat (350) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("halt_hold_busy", n, 0);
        halt = 1'b0;
        run_frame(1'b1, 1'b0, 961, -1);
        chk("halt_release_immediate", 32'(first_busy), 1);

        go = 1'b0;
        n = 0;
        repeat (250) begin
            @(negedge clk);
            if (busy) n++;
        end
        chk("idle_busy", n, 0);
        chk("idle_wall_x_kept", wall_x, exp_wall_x);
        go = 1'b1;
        run_frame(1'b0, 1'b0, 480, 200);

        go = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_reset_busy", busy, 0);
        chk("post_reset_wall_x", wall_x, 160);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wall_control.md
Name: wall_control

Overview:
- Sequencer for the scrolling-wall obstacle in the 160x120 VGA game.
- Paces wall motion to a frame tick and each frame runs: erase old wall column, advance wall position, pick a new hole on wrap, draw new wall.
- Owns wall position and hole position.
- Streams pixels to the VGA plotting interface with a valid/ready handshake.

Parameters:
- FRAME_DIV, 833333: clocks per frame tick (50 MHz / 60).
- WALL_SPEED, 4: pixels moved left per frame.
- WALL_W, 4: wall width in pixels.
- SCREEN_W, 160: wall reload x.
- SCREEN_H, 120: rows per column.
- HOLE_H, 40: hole height in rows.
- WALL_COLOUR, 3'b010: colour of solid wall pixels.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- resetn  in  1  asynchronous active-low reset.
- go  in  1  level; start or continue the game while high.
- halt  in  1  level; collision freeze; takes effect only in WAIT_FRAME.
- plot_ready  in  1  VGA side accepts the current pixel this cycle.
- plot  out  1  pixel valid.
- x  out  8  pixel x.
- y  out  7  pixel y.
- colour  out  3  pixel colour.
- wall_x  out  8  current wall left edge.
- hole_top  out  7  first hole row.
- busy  out  1  high in ERASE, MOVE and DRAW.
- frame_done  out  1  one-cycle pulse at the end of DRAW.

Behaviour:
- Reset values (async, resetn=0):
  - state IDLE, wall_x=160, hole_top=40, lfsr=8'hA5, frame counter 0, tick_pending 0.
  - plot=0, x=0, y=0, colour=0, busy=0, frame_done=0.
- Frame counter:
  - Counts 0..FRAME_DIV-1 in every state except IDLE; cleared in IDLE.
  - Wrap sets tick_pending. Pending is one-deep; a wrap while pending is already set is dropped.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, steps every clock and is never zero.
- IDLE:
  - plot=0.
  - go=1 -> DRAW, which draws the initial wall at the reset position. No erase.
- WAIT_FRAME:
  - go=0 -> IDLE. wall_x and hole_top are kept.
  - go=1 and halt=1 -> stay. tick_pending is left untouched.
  - go=1, halt=0, tick_pending=1 -> clear pending, go to ERASE.
- ERASE:
  - Scan y outer 0..SCREEN_H-1, x inner wall_x..wall_x+WALL_W-1. colour=0.
  - For each coordinate: if x<SCREEN_W, assert plot with x,y,colour stable and advance only on plot&plot_ready. Otherwise the coordinate is skipped in one cycle with plot=0.
  - After the last coordinate -> MOVE.
- MOVE (exactly one cycle, plot=0):
  - If wall_x < WALL_SPEED: wall_x=SCREEN_W and hole_top = 8 + lfsr[5:0] (range 8..71).
  - Otherwise wall_x = wall_x - WALL_SPEED. 8-bit unsigned arithmetic; underflow is impossible given this guard.
  - Then -> DRAW.
- DRAW:
  - Same scan and handshake as ERASE.
  - colour=0 for rows where hole_top <= y < hole_top+HOLE_H; WALL_COLOUR for all other rows.
  - After the last coordinate: pulse frame_done, go to WAIT_FRAME.
- With wall_x=SCREEN_W the wall is fully clipped: each pass takes SCREEN_H*WALL_W cycles with no plots.
- go and halt are ignored during busy states; a started frame always completes.
- x and y hold their value while plot=1 and plot_ready=0.
- Reset asserted mid-scan aborts immediately to the reset values. No partial-pixel cleanup.
- tick_pending is not set by wraps during busy unless already clear; an overrun beyond one frame is lost.

Test Plan (bench uses FRAME_DIV=100, plot_ready=1 unless stated):
- Reset, go=1 -> first pass is DRAW at wall_x=160: 480 cycles, zero plot pulses, then frame_done pulses; busy high throughout.
- After the first tick -> ERASE (0 plots), MOVE gives wall_x=156, DRAW gives 480 plots at x 156..159. Rows 40..79 have colour 0, all other rows 3'b010.
- Step frames until wall_x=0; the next MOVE must give wall_x=160 and hole_top = 8 + lfsr[5:0] sampled that cycle, with hole_top in 8..71. Check ERASE at wall_x=0 covers x 0..3.
- Toggle plot_ready randomly at 50% during DRAW -> exactly 480 accepted pixels, no duplicates or gaps, and x/y/colour stable while stalled.
- Hold halt=1 in WAIT_FRAME across 3 counter wraps -> no ERASE starts. Release -> exactly one frame runs immediately, then the next waits for a fresh tick.
- Pull resetn low mid-DRAW (pixel 200) -> plot=0, state IDLE, wall_x=160, hole_top=40 in the same cycle (asynchronous). go=0 in WAIT_FRAME -> IDLE and the counter clears.
